// File: rtl/button_conditioner.sv
// button_conditioner: CHANNELS independent mechanical inputs, each with a
// 2-flop synchronizer, optional active-low inversion, time-based debounce,
// one-cycle rise/fall pulses and a one-shot long-press pulse.
// Optional auto-repeat after a long press is compiled in when the macro
// BUTTON_CONDITIONER_AUTOREPEAT_EN is defined; otherwise rpt is tied to 0.
module button_conditioner #(
  parameter int unsigned         CHANNELS      = 4,
  parameter int unsigned         DEB_CYCLES    = 1000000,
  parameter int unsigned         HOLD_CYCLES   = 100000000,
  parameter int unsigned         REPEAT_CYCLES = 10000000,
  parameter logic [CHANNELS-1:0] INVERT        = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] rpt
);

  localparam int unsigned     DW        = $clog2(DEB_CYCLES);
  localparam int unsigned     HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("button_conditioner: CHANNELS must be 1..32");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("button_conditioner: DEB_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("button_conditioner: HOLD_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_CYCLES must be >= 2");
  end

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] smp;
  logic [CHANNELS-1:0] clean_q, clean_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] long_q, long_d;
  logic [DW-1:0]       deb_cnt_q [CHANNELS];
  logic [DW-1:0]       deb_cnt_d [CHANNELS];
  logic [HW-1:0]       hold_q    [CHANNELS];
  logic [HW-1:0]       hold_d    [CHANNELS];

  // Synchronized sample with polarity normalised so 1 always means pressed.
  assign smp = sync2_q ^ INVERT;

  // Per-channel debounce and long-press next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    long_d  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      hold_d[i]    = hold_q[i];

      // A return to the current level at any point restarts the count.
      if (smp[i] == clean_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        clean_d[i]   = smp[i];
        deb_cnt_d[i] = '0;
        rise_d[i]    = smp[i];
        fall_d[i]    = ~smp[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end

      // Hold counter saturates at HOLD_CYCLES so each press fires once.
      if (!clean_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] < HOLD_MAX) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end

      long_d[i] = clean_q[i] && (hold_q[i] == HOLD_LAST);
    end
  end

  // Synchronizer, debounce and pulse registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      sync1_q <= INVERT;
      sync2_q <= INVERT;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      long_q  <= '0;
      // NOTE: the counter arrays are reset explicitly because an interrupted
      // debounce or hold must not resume after reset; they are flops, not RAM.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        deb_cnt_q[i] <= '0;
        hold_q[i]    <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        hold_q[i]    <= hold_d[i];
      end
    end
  end

  assign clean      = clean_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = long_q;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned   RW       = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0]       rep_q [CHANNELS];
  logic [RW-1:0]       rep_d [CHANNELS];
  logic [CHANNELS-1:0] rpt_q, rpt_d;

  // Repeat counter runs only once the hold counter has saturated (post long press).
  always_comb begin
    rpt_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rep_d[i] = rep_q[i];
      if (!clean_q[i] || long_d[i]) begin
        rep_d[i] = '0;
      end else if (hold_q[i] == HOLD_MAX) begin
        if (rep_q[i] == REP_LAST) begin
          rep_d[i] = '0;
          // A release landing on a repeat slot wins; no rpt alongside fall.
          rpt_d[i] = ~fall_d[i];
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
    end
  end

  // Repeat counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rep_q[i] <= '0;
      end
    end else begin
      rpt_q <= rpt_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rep_q[i] <= rep_d[i];
      end
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEB_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=3, CHANNELS=4, INVERT=4'b1000.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_button_conditioner;

  localparam int unsigned CH = 4;

  logic          clk;
  logic          rst;
  logic [CH-1:0] raw;
  logic [CH-1:0] clean, rise, fall, long_press, rpt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  button_conditioner #(
    .CHANNELS      (CH),
    .DEB_CYCLES    (4),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (3),
    .INVERT        (4'b1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw        (raw),
    .clean      (clean),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press),
    .rpt        (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [CH-1:0] raw;
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] lp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [CH-1:0] rw,
                              input logic [CH-1:0] c, input logic [CH-1:0] ri,
                              input logic [CH-1:0] f, input logic [CH-1:0] l);
    vec_t v;
    v.rst = r; v.raw = rw; v.clean = c; v.rise = ri; v.fall = f; v.lp = l;
    tbl.push_back(v);
  endfunction

  // Observed outputs packed as {clean, rise, fall, long_press, rpt}.
  function automatic logic [5*CH-1:0] observed();
    return {clean, rise, fall, long_press, rpt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5*CH-1:0] act,
                       input logic [5*CH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {clean,rise,fall,long,rpt}=%h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [CH-1:0] e_clean, e_rise, e_fall, e_lp, e_rpt;

    rst = 1'b1;
    raw = 4'b1000;

    // Reset, 20 idle cycles, ch0 press/release with boundary on long press.
    add(1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) add(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++)  add(1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++)  add(1'b0, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // Released before edge 9: clean stays up through edge 13 (9 cycles, no long press).
    for (int i = 0; i < 5; i++)  add(1'b0, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    for (int i = 0; i < 2; i++)  add(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      raw = tbl[i].raw;
      step();
      check($sformatf("tbl[%0d]", i), observed(),
            {tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].lp, 4'b0000});
    end

    // Glitch rejection: ch1 high 3 cycles / low 3 cycles, five times.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 6; j++) begin
        raw = (j < 3) ? 4'b1010 : 4'b1000;
        step();
        check($sformatf("glitch r%0d c%0d", r, j), observed(), '0);
      end
    end
    raw = 4'b1000;
    for (int j = 0; j < 6; j++) begin
      step();
      check($sformatf("glitch settle %0d", j), observed(), '0);
    end

    // Long press on ch2: held through edge 30, released before edge 31.
    for (int e = 0; e <= 40; e++) begin
      raw = (e <= 30) ? 4'b1100 : 4'b1000;
      step();
      e_clean = (e >= 5 && e <= 35) ? 4'b0100 : 4'b0000;
      e_rise  = (e == 5)  ? 4'b0100 : 4'b0000;
      e_fall  = (e == 36) ? 4'b0100 : 4'b0000;
      e_lp    = (e == 15) ? 4'b0100 : 4'b0000;
      e_rpt   = 4'b0000;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      // Repeats at 18,21,...,33; the slot at 36 coincides with fall and is suppressed.
      if (e >= 18 && e <= 35 && (e % 3) == 0) e_rpt = 4'b0100;
`endif
      check($sformatf("long e%0d", e), observed(), {e_clean, e_rise, e_fall, e_lp, e_rpt});
    end

    // Simultaneous ch0 press and ch3 (active-low) press.
    for (int e = 0; e <= 14; e++) begin
      raw = (e <= 5) ? 4'b0001 : 4'b1000;
      step();
      e_clean = (e >= 5 && e <= 10) ? 4'b1001 : 4'b0000;
      e_rise  = (e == 5)  ? 4'b1001 : 4'b0000;
      e_fall  = (e == 11) ? 4'b1001 : 4'b0000;
      check($sformatf("simul e%0d", e), observed(), {e_clean, e_rise, e_fall, 8'h00});
    end

    // Reset mid-count: ch0 pressed before edge 0, rst high at edges 3 and 4.
    // First post-reset edge is 5, so rise lands on edge 10.
    for (int e = 0; e <= 11; e++) begin
      rst = (e == 3 || e == 4);
      raw = 4'b1001;
      step();
      e_clean = (e >= 10) ? 4'b0001 : 4'b0000;
      e_rise  = (e == 10) ? 4'b0001 : 4'b0000;
      check($sformatf("rstmid e%0d", e), observed(), {e_clean, e_rise, 12'h000});
    end
    rst = 1'b0;
    raw = 4'b1000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the single-channel debouncer: CHANNELS independent mechanical inputs (push-buttons, switches).
- Per channel: 2-flop synchronizer, optional polarity inversion, time-based debounce, one-cycle press/release pulses, long-press detection.
- Sits between board pins and the clock's control FSM (set/mode/increment keys), so the FSM consumes clean pulses and never edge-detects or times bounce itself.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- DEB_CYCLES, 1000000, consecutive cycles the synchronized input must differ from clean before clean flips (20 ms @ 50 MHz); must be >= 2.
- HOLD_CYCLES, 100000000, cycles clean must stay 1 before a long-press pulse (2 s @ 50 MHz); must be >= 2.
- REPEAT_CYCLES, 10000000, auto-repeat period after long press (Optional Feature only); must be >= 2.
- INVERT, {CHANNELS{1'b0}}, per-channel mask; bit=1 means the input is active-low (inverted after the synchronizer).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- raw, input, CHANNELS, asynchronous raw inputs from pins.
- clean, output, CHANNELS, debounced level (1 = pressed after INVERT).
- rise, output, CHANNELS, one-cycle pulse when clean goes 0->1.
- fall, output, CHANNELS, one-cycle pulse when clean goes 1->0.
- long_press, output, CHANNELS, one-cycle pulse after clean has been 1 for HOLD_CYCLES.
- rpt, output, CHANNELS, auto-repeat pulses (constant 0 without AUTOREPEAT_EN).

Behaviour:
- Reset (rst=1 at posedge): sync1[i], sync2[i] <= INVERT[i]; clean, rise, fall, long_press, rpt <= 0; all counters <= 0. Outputs stay 0 through the first cycle after reset is released, and no pulse is emitted on reset exit.
- Synchronizer: sync1 <= raw; sync2 <= sync1. smp[i] = sync2[i] ^ INVERT[i] (combinational).
- Debounce per channel, counter width $clog2(DEB_CYCLES):
  - smp == clean: cnt <= 0.
  - else if cnt == DEB_CYCLES-1: clean <= smp; cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: with raw changing before edge k and held stable, clean changes at edge k+DEB_CYCLES+1, i.e. the (DEB_CYCLES+2)th edge.
- Glitch rejection: any return to smp == clean before the count completes restarts it from 0. A pulse of fewer than DEB_CYCLES stable synchronized cycles never changes clean.
- rise[i]/fall[i] are registered at the same edge clean flips, so they are coincident with the new clean level and high for exactly one cycle. They are never both high; no pulses occur on non-flip cycles.
- Long press, hold counter per channel, width $clog2(HOLD_CYCLES)+1:
  - clean == 0: hold <= 0.
  - clean == 1 and hold < HOLD_CYCLES: hold <= hold+1.
  - long_press <= 1 for one cycle at the edge where hold == HOLD_CYCLES-1 (HOLD_CYCLES cycles after rise).
  - hold then saturates at HOLD_CYCLES: one long_press per press. Release (fall) clears hold; a re-press restarts timing.
- Channels are fully independent; simultaneous events on different channels are each reported in the same cycle.
- Reset mid-count discards in-progress debounce/hold state; no pulse is produced for the interrupted event.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
- Defined: per-channel repeat counter, width $clog2(REPEAT_CYCLES).
  - Cleared at long_press and whenever clean == 0.
  - After long_press, while clean == 1, it counts; rpt pulses one cycle every REPEAT_CYCLES cycles. First rpt comes REPEAT_CYCLES cycles after long_press; the counter wraps to 0 on each pulse.
  - fall or rst stops repetition immediately. rpt is never asserted in the same cycle as fall.
- Undefined: no repeat counter logic; rpt tied to 0; REPEAT_CYCLES ignored.

Test Plan (DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, CHANNELS=4, INVERT=4'b1000):
- Reset then idle (raw=4'b1000) for 20 cycles -> clean=0, all pulses 0 throughout; ch3 idle-high reads released.
- raw[0] 0->1 before edge 0, held -> clean[0]=1 and rise[0]=1 after edge 5; rise[0] low after edge 6.
- raw[1] high for 3 cycles then low, repeated 5x -> clean[1], rise[1], fall[1] stay 0.
- raw[2] pressed and held 30 cycles -> rise[2] at edge N, long_press[2] exactly once at N+10. With macro: rpt[2] at N+13, N+16, N+19 ...; on release, fall[2] and no further rpt.
- raw[0] and raw[3] (active-low 1->0) change on the same cycle -> rise[0] and rise[3] asserted in the same cycle.
- rst asserted 2 cycles after raw[0] press (cnt mid-count), released while raw held -> no rise before reset; rise[0] at the 6th edge counted from the first post-reset edge.
